pc_sequencer: RTL and testbench

Fetch/execute controller that drives the Hack program counter (PC) load/inc/reset inputs.
- Requests each instruction from ROM over a req/ack handshake and latches it into an instruction register.
- Evaluates the C-instruction jump bits against the ALU flags and commits exactly one PC update per instruction.
- Provides run/halt and single-step control for board-level debugging.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_jump_eval.sv | 16 +
 rtl/pc_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the Hack fetch/execute sequencer and the CPU decode:
// FSM state values and the instruction bit positions used for jump evaluation.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    localparam int C_FLAG_BIT = 15;

    // Jump field bit positions inside a C-instruction.
    localparam int J_LT_BIT = 2;
    localparam int J_EQ_BIT = 1;
    localparam int J_GT_BIT = 0;

endpackage

// File: rtl/pc_sequencer_jump_eval.sv
// Combinational jump condition from the C-instruction jump bits and ALU flags.
// Zero latency; no flow control.
module jump_eval
    import pc_sequencer_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       jump
);

    assign jump = (j[J_LT_BIT] & ng)
                | (j[J_EQ_BIT] & zr)
                | (j[J_GT_BIT] & ~zr & ~ng);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller driving the Hack PC: one PC update per instruction.
// Two cycles per instruction with ROM ack tied high; FETCH stalls indefinitely on rom_ack=0.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] BOOT_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             rom_ack,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] a_reg,
    input  logic             zr,
    input  logic             ng,
    output logic             rom_req,
    output logic             pc_reset,
    output logic             pc_load,
    output logic             pc_inc,
    output logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] ir,
    output logic             exec,
    output logic             jump_taken,
    output logic             halted,
    output logic [15:0]      icount
);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [15:0]      icount_q, icount_d;
    logic             step_pending_q, step_pending_d;
    logic             jump;

    jump_eval u_jump_eval (
        .j    ({ir_q[J_LT_BIT], ir_q[J_EQ_BIT], ir_q[J_GT_BIT]}),
        .zr   (zr),
        .ng   (ng),
        .jump (jump)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_BOOT;
            ir_q           <= '0;
            icount_q       <= '0;
            step_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ir_q           <= ir_d;
            icount_q       <= icount_d;
            step_pending_q <= step_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        icount_d       = icount_q;
        step_pending_d = step_pending_q;
        case (state_q)
            ST_BOOT: state_d = run ? ST_FETCH : ST_HALT;
            ST_FETCH: begin
                if (rom_ack) begin
                    ir_d    = instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                icount_d = icount_q + 16'd1;
                if (run && !step_pending_q) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d        = ST_HALT;
                    step_pending_d = 1'b0;
                end
            end
            ST_HALT: begin
                // A step only counts as single-step when not free-running.
                if (run) begin
                    state_d = ST_FETCH;
                end else if (step) begin
                    state_d        = ST_FETCH;
                    step_pending_d = 1'b1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        rom_req    = 1'b0;
        pc_reset   = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_in      = '0;
        exec       = 1'b0;
        jump_taken = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (BOOT_ADDR == '0) begin
                    pc_reset = 1'b1;
                end else begin
                    pc_load = 1'b1;
                    pc_in   = BOOT_ADDR;
                end
            end
            ST_FETCH: rom_req = 1'b1;
            ST_EXEC: begin
                exec = 1'b1;
                if (ir_q[C_FLAG_BIT] && jump) begin
                    pc_load    = 1'b1;
                    pc_in      = a_reg;
                    jump_taken = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign ir     = ir_q;
    assign icount = icount_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, jumps, ROM wait states, halt/step, reset mid-fetch.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        rom_ack = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [15:0] a_reg = 16'h0000;
    logic        zr = 1'b0;
    logic        ng = 1'b0;
    logic        rom_req, pc_reset, pc_load, pc_inc, exec, jump_taken, halted;
    logic [15:0] pc_in, ir, icount;
    logic [6:0]  ctl;

    int tests_run = 0;
    int fails = 0;

    // {rom_req, pc_reset, pc_load, pc_inc, exec, jump_taken, halted}
    localparam logic [6:0] CTL_FETCH = 7'b1000000;
    localparam logic [6:0] CTL_BOOT  = 7'b0100000;
    localparam logic [6:0] CTL_JMP   = 7'b0010110;
    localparam logic [6:0] CTL_INC   = 7'b0001100;
    localparam logic [6:0] CTL_HALT  = 7'b0000001;

    always #5 clk = ~clk;

    assign ctl = {rom_req, pc_reset, pc_load, pc_inc, exec, jump_taken, halted};

    pc_sequencer #(.WIDTH(16), .BOOT_ADDR(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .rom_ack    (rom_ack),
        .instr      (instr),
        .a_reg      (a_reg),
        .zr         (zr),
        .ng         (ng),
        .rom_req    (rom_req),
        .pc_reset   (pc_reset),
        .pc_load    (pc_load),
        .pc_inc     (pc_inc),
        .pc_in      (pc_in),
        .ir         (ir),
        .exec       (exec),
        .jump_taken (jump_taken),
        .halted     (halted),
        .icount     (icount)
    );

    // Advance one clock; inputs are then changed at posedge+1, outputs read at posedge+2.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic run_v);
        reset   = 1'b1;
        run     = run_v;
        step    = 1'b0;
        rom_ack = 1'b0;
        nxt();
        reset = 1'b0;
        nxt();
    endtask

    // From FETCH: present instr with ack, land in EXEC with the given flags.
    task automatic exec_one(input logic [15:0] instr_v, input logic zr_v, input logic ng_v);
        rom_ack = 1'b1;
        instr   = instr_v;
        nxt();
        rom_ack = 1'b0;
        zr      = zr_v;
        ng      = ng_v;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b0;
        nxt();
        nxt();
        reset = 1'b0;
        run   = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_BOOT) begin
            fails++;
            $display("FAIL reset_boot_ctl: got %b want %b", ctl, CTL_BOOT);
        end
        tests_run++;
        if (icount !== 16'h0000 || ir !== 16'h0000) begin
            fails++;
            $display("FAIL reset_regs: icount=%h ir=%h want 0000 0000", icount, ir);
        end
        nxt();
        tests_run++;
        if (ctl !== CTL_FETCH) begin
            fails++;
            $display("FAIL reset_to_fetch: got %b want %b", ctl, CTL_FETCH);
        end
    endtask

    task automatic test_boot_halt();
        do_reset(1'b0);
        tests_run++;
        if (ctl !== CTL_HALT) begin
            fails++;
            $display("FAIL boot_halt: got %b want %b", ctl, CTL_HALT);
        end
    endtask

    task automatic test_uncond_jump();
        do_reset(1'b1);
        a_reg = 16'h0010;
        exec_one(16'h0005, 1'b0, 1'b0);
        tests_run++;
        if (ctl !== CTL_INC || ir !== 16'h0005) begin
            fails++;
            $display("FAIL ainstr_exec: ctl=%b ir=%h want %b 0005", ctl, ir, CTL_INC);
        end
        nxt();
        exec_one(16'hEA87, 1'b0, 1'b1);
        tests_run++;
        if (ctl !== CTL_JMP || pc_in !== 16'h0010) begin
            fails++;
            $display("FAIL jmp_exec: ctl=%b pc_in=%h want %b 0010", ctl, pc_in, CTL_JMP);
        end
        nxt();
        tests_run++;
        if (icount !== 16'd2 || ctl !== CTL_FETCH) begin
            fails++;
            $display("FAIL jmp_icount: icount=%0d ctl=%b want 2 %b", icount, ctl, CTL_FETCH);
        end
    endtask

    task automatic test_cond_jumps();
        do_reset(1'b1);
        a_reg = 16'h1234;
        exec_one(16'hE301, 1'b0, 1'b0);
        tests_run++;
        if (ctl !== CTL_JMP || pc_in !== 16'h1234) begin
            fails++;
            $display("FAIL jgt_taken: ctl=%b pc_in=%h want %b 1234", ctl, pc_in, CTL_JMP);
        end
        nxt();
        exec_one(16'hE301, 1'b1, 1'b0);
        tests_run++;
        if (ctl !== CTL_INC) begin
            fails++;
            $display("FAIL jgt_not_taken: got %b want %b", ctl, CTL_INC);
        end
        nxt();
        exec_one(16'hE302, 1'b1, 1'b0);
        tests_run++;
        if (ctl !== CTL_JMP) begin
            fails++;
            $display("FAIL jeq_taken: got %b want %b", ctl, CTL_JMP);
        end
        nxt();
        exec_one(16'hE304, 1'b0, 1'b0);
        tests_run++;
        if (ctl !== CTL_INC) begin
            fails++;
            $display("FAIL jlt_not_taken: got %b want %b", ctl, CTL_INC);
        end
        nxt();
        exec_one(16'hE304, 1'b0, 1'b1);
        tests_run++;
        if (ctl !== CTL_JMP) begin
            fails++;
            $display("FAIL jlt_taken: got %b want %b", ctl, CTL_JMP);
        end
        nxt();
        tests_run++;
        if (icount !== 16'd5) begin
            fails++;
            $display("FAIL cond_icount: got %0d want 5", icount);
        end
    endtask

    task automatic test_wait_states();
        do_reset(1'b1);
        instr = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                rom_ack = 1'b1;
                instr   = 16'h0042;
            end
            #1;
            tests_run++;
            if (ctl !== CTL_FETCH || ir !== 16'h0000) begin
                fails++;
                $display("FAIL wait_fetch_%0d: ctl=%b ir=%h want %b 0000", i, ctl, ir, CTL_FETCH);
            end
            nxt();
        end
        rom_ack = 1'b0;
        instr   = 16'hFFFF;
        #1;
        tests_run++;
        if (ctl !== CTL_INC || ir !== 16'h0042) begin
            fails++;
            $display("FAIL wait_exec: ctl=%b ir=%h want %b 0042", ctl, ir, CTL_INC);
        end
    endtask

    task automatic test_halt_step();
        do_reset(1'b1);
        run = 1'b0;
        nxt();
        tests_run++;
        if (ctl !== CTL_FETCH) begin
            fails++;
            $display("FAIL halt_fetch_continues: got %b want %b", ctl, CTL_FETCH);
        end
        exec_one(16'h0007, 1'b0, 1'b0);
        tests_run++;
        if (ctl !== CTL_INC) begin
            fails++;
            $display("FAIL halt_finishes_instr: got %b want %b", ctl, CTL_INC);
        end
        nxt();
        nxt();
        tests_run++;
        if (ctl !== CTL_HALT || icount !== 16'd1) begin
            fails++;
            $display("FAIL halted_state: ctl=%b icount=%0d want %b 1", ctl, icount, CTL_HALT);
        end
        step = 1'b1;
        nxt();
        step = 1'b0;
        #1;
        tests_run++;
        if (ctl !== CTL_FETCH) begin
            fails++;
            $display("FAIL step_fetch: got %b want %b", ctl, CTL_FETCH);
        end
        exec_one(16'h0008, 1'b0, 1'b0);
        tests_run++;
        if (ctl !== CTL_INC) begin
            fails++;
            $display("FAIL step_exec: got %b want %b", ctl, CTL_INC);
        end
        nxt();
        nxt();
        tests_run++;
        if (ctl !== CTL_HALT || icount !== 16'd2) begin
            fails++;
            $display("FAIL step_one_instr: ctl=%b icount=%0d want %b 2", ctl, icount, CTL_HALT);
        end
        run  = 1'b1;
        step = 1'b1;
        nxt();
        step = 1'b0;
        exec_one(16'h0009, 1'b0, 1'b0);
        nxt();
        tests_run++;
        if (ctl !== CTL_FETCH || icount !== 16'd3) begin
            fails++;
            $display("FAIL step_with_run_ignored: ctl=%b icount=%0d want %b 3", ctl, icount, CTL_FETCH);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset(1'b1);
        exec_one(16'h0003, 1'b0, 1'b0);
        nxt();
        reset   = 1'b1;
        rom_ack = 1'b1;
        instr   = 16'hFFFF;
        nxt();
        reset = 1'b0;
        #1;
        tests_run++;
        if (ctl !== CTL_BOOT || ir !== 16'h0000 || icount !== 16'h0000) begin
            fails++;
            $display("FAIL reset_mid_fetch: ctl=%b ir=%h icount=%h want %b 0000 0000",
                     ctl, ir, icount, CTL_BOOT);
        end
        nxt();
        rom_ack = 1'b0;
        #1;
        tests_run++;
        if (ctl !== CTL_FETCH || ir !== 16'h0000) begin
            fails++;
            $display("FAIL reset_ack_ignored: ctl=%b ir=%h want %b 0000", ctl, ir, CTL_FETCH);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_boot_halt();
        test_uncond_jump();
        test_cond_jumps();
        test_wait_states();
        test_halt_step();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
